// File: rtl/sdht_pkg.sv
// Shared definitions for the static distance Huffman code path (encoder and decoder).
// Holds the FSM state encoding, field-width constants, the distance code points
// and the base/extra-count lookup entry type.
package sdht_pkg;

  localparam int CODE_BITS      = 5;
  localparam int MAX_EXTRA_BITS = 13;
  localparam int MAX_CODE       = 29;
  localparam int BASE_BITS      = 17;  // 24577 + 8191 = 32768 needs 16 bits; base math keeps one spare

  typedef enum logic [1:0] {
    S_CODE  = 2'd0,
    S_EXTRA = 2'd1,
    S_OUT   = 2'd2
  } sdht_state_t;

  // Result of mapping one distance code: first distance of its range,
  // number of extra bits that follow it, and whether the code is unused (30/31).
  typedef struct packed {
    logic [BASE_BITS-1:0] base;
    logic [3:0]           extra_no;
    logic                 invalid;
  } sdht_lut_t;

  localparam logic [CODE_BITS-1:0] DIST_CODE0  = 5'd0;
  localparam logic [CODE_BITS-1:0] DIST_CODE1  = 5'd1;
  localparam logic [CODE_BITS-1:0] DIST_CODE2  = 5'd2;
  localparam logic [CODE_BITS-1:0] DIST_CODE3  = 5'd3;
  localparam logic [CODE_BITS-1:0] DIST_CODE4  = 5'd4;
  localparam logic [CODE_BITS-1:0] DIST_CODE5  = 5'd5;
  localparam logic [CODE_BITS-1:0] DIST_CODE6  = 5'd6;
  localparam logic [CODE_BITS-1:0] DIST_CODE7  = 5'd7;
  localparam logic [CODE_BITS-1:0] DIST_CODE8  = 5'd8;
  localparam logic [CODE_BITS-1:0] DIST_CODE9  = 5'd9;
  localparam logic [CODE_BITS-1:0] DIST_CODE10 = 5'd10;
  localparam logic [CODE_BITS-1:0] DIST_CODE11 = 5'd11;
  localparam logic [CODE_BITS-1:0] DIST_CODE12 = 5'd12;
  localparam logic [CODE_BITS-1:0] DIST_CODE13 = 5'd13;
  localparam logic [CODE_BITS-1:0] DIST_CODE14 = 5'd14;
  localparam logic [CODE_BITS-1:0] DIST_CODE15 = 5'd15;
  localparam logic [CODE_BITS-1:0] DIST_CODE16 = 5'd16;
  localparam logic [CODE_BITS-1:0] DIST_CODE17 = 5'd17;
  localparam logic [CODE_BITS-1:0] DIST_CODE18 = 5'd18;
  localparam logic [CODE_BITS-1:0] DIST_CODE19 = 5'd19;
  localparam logic [CODE_BITS-1:0] DIST_CODE20 = 5'd20;
  localparam logic [CODE_BITS-1:0] DIST_CODE21 = 5'd21;
  localparam logic [CODE_BITS-1:0] DIST_CODE22 = 5'd22;
  localparam logic [CODE_BITS-1:0] DIST_CODE23 = 5'd23;
  localparam logic [CODE_BITS-1:0] DIST_CODE24 = 5'd24;
  localparam logic [CODE_BITS-1:0] DIST_CODE25 = 5'd25;
  localparam logic [CODE_BITS-1:0] DIST_CODE26 = 5'd26;
  localparam logic [CODE_BITS-1:0] DIST_CODE27 = 5'd27;
  localparam logic [CODE_BITS-1:0] DIST_CODE28 = 5'd28;
  localparam logic [CODE_BITS-1:0] DIST_CODE29 = 5'd29;

endpackage

// File: rtl/sdht_dec_base_lut.sv
// Purpose: map a 5-bit distance code to {base, extra bit count, invalid}.
// Latency: combinational. Backpressure: none (pure function of code).
// Ports: code (in, 5b) -> ent (out, sdht_lut_t).
module sdht_dec_base_lut
  import sdht_pkg::*;
(
  input  logic [CODE_BITS-1:0] code,
  output sdht_lut_t            ent
);

  // Codes 4..29 come in pairs sharing an extra-bit count; the low code bit picks
  // the lower or upper half of the doubled range, so base = ({1,c[0]} << n) + 1.
  logic [BASE_BITS-1:0] mant;
  logic [3:0]           n_big;

  assign mant  = {{(BASE_BITS-2){1'b0}}, 1'b1, code[0]};
  assign n_big = code[4:1] - 4'd1;

  always_comb begin
    ent = '0;
    if (code > 5'(MAX_CODE)) begin
      ent.invalid = 1'b1;
    end else if (code <= DIST_CODE3) begin
      // No extra bits: the code alone names distances 1..4.
      ent.base     = {{(BASE_BITS-CODE_BITS){1'b0}}, code} + 17'd1;
      ent.extra_no = 4'd0;
    end else begin
      ent.base     = (mant << n_big) + 17'd1;
      ent.extra_no = n_big;
    end
  end

endmodule

// File: rtl/sdht_decoder.sv
// Purpose: serial static-Huffman distance decoder (5 code bits MSB first, then n extra bits MSB first).
// Latency: dist_valid_out rises the cycle after the last field bit is accepted; one result per 5+n+1 cycles min.
// Backpressure: bit_ready_out drops while a result waits in S_OUT; result held until dist_ready_in.
// Ports: clk, rst_n (async, active low); bit_in/bit_valid_in/bit_ready_out serial input;
//        dist_out/dist_err_out/dist_valid_out/dist_ready_in result output.
module sdht_decoder
  import sdht_pkg::*;
#(
  // Width of the reconstructed distance; must be >= 16 so that 32768 fits.
  parameter int DICTIONARY_DEPTH_LOG = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            bit_in,
  input  logic                            bit_valid_in,
  output logic                            bit_ready_out,
  output logic [DICTIONARY_DEPTH_LOG-1:0] dist_out,
  output logic                            dist_err_out,
  output logic                            dist_valid_out,
  input  logic                            dist_ready_in
);

  sdht_state_t               state;
  logic [3:0]                cnt;
  logic [CODE_BITS-1:0]      code_q;
  logic [MAX_EXTRA_BITS-1:0] ext_q;

  logic                      accept;
  logic [CODE_BITS-1:0]      code_full;
  logic [CODE_BITS-1:0]      lut_code;
  logic [MAX_EXTRA_BITS-1:0] ext_full;
  logic [MAX_EXTRA_BITS:0]   ext_mask;
  logic [BASE_BITS-1:0]      ext_sum;
  sdht_lut_t                 lut;

  assign bit_ready_out  = (state != S_OUT);
  assign dist_valid_out = (state == S_OUT);
  assign accept         = bit_valid_in && bit_ready_out;

  // Code including the bit arriving this cycle; decides the 5th-bit transition.
  assign code_full = {code_q[3:0], bit_in};
  assign ext_full  = {ext_q[MAX_EXTRA_BITS-2:0], bit_in};

  // While collecting extra bits the stored code drives the LUT; before that the
  // incoming bit completes the code so the decision lands on the 5th edge.
  assign lut_code = (state == S_EXTRA) ? code_q : code_full;

  sdht_dec_base_lut u_lut (
    .code (lut_code),
    .ent  (lut)
  );

  // One extra bit of mask width so n = 13 yields all ones without overflow.
  assign ext_mask = (14'd1 << lut.extra_no) - 14'd1;
  assign ext_sum  = lut.base + {{(BASE_BITS-MAX_EXTRA_BITS){1'b0}},
                                ext_full & ext_mask[MAX_EXTRA_BITS-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_CODE;
      cnt          <= '0;
      code_q       <= '0;
      ext_q        <= '0;
      dist_out     <= '0;
      dist_err_out <= 1'b0;
    end else begin
      case (state)
        S_CODE: begin
          if (accept) begin
            code_q <= code_full;
            if (cnt == 4'(CODE_BITS - 1)) begin
              cnt <= '0;
              if (lut.invalid) begin
                dist_out     <= '0;
                dist_err_out <= 1'b1;
                state        <= S_OUT;
              end else if (lut.extra_no == 4'd0) begin
                dist_out     <= DICTIONARY_DEPTH_LOG'(lut.base);
                dist_err_out <= 1'b0;
                state        <= S_OUT;
              end else begin
                state <= S_EXTRA;
              end
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        S_EXTRA: begin
          if (accept) begin
            ext_q <= ext_full;
            if (cnt == lut.extra_no - 4'd1) begin
              dist_out     <= DICTIONARY_DEPTH_LOG'(ext_sum);
              dist_err_out <= 1'b0;
              cnt          <= '0;
              state        <= S_OUT;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        S_OUT: begin
          // Result registers are left alone so they stay stable across the handshake.
          if (dist_ready_in) begin
            state  <= S_CODE;
            cnt    <= '0;
            code_q <= '0;
            ext_q  <= '0;
          end
        end
        default: state <= S_CODE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdht_decoder.sv
// Purpose: directed and round-trip checks of sdht_decoder against hand-computed distances.
// Latency: checks valid one cycle after the last accepted bit.
// Backpressure: exercises held results, input gaps and mid-field reset.
module tb_sdht_decoder;

  logic        clk;
  logic        rst_n;
  logic        bit_in;
  logic        bit_valid_in;
  logic        bit_ready_out;
  logic [15:0] dist_out;
  logic        dist_err_out;
  logic        dist_valid_out;
  logic        dist_ready_in;

  int n_vec;
  int n_err;

  sdht_decoder #(.DICTIONARY_DEPTH_LOG(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bit_in         (bit_in),
    .bit_valid_in   (bit_valid_in),
    .bit_ready_out  (bit_ready_out),
    .dist_out       (dist_out),
    .dist_err_out   (dist_err_out),
    .dist_valid_out (dist_valid_out),
    .dist_ready_in  (dist_ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives one bit from a negedge and returns right after the accepting posedge.
  task automatic send_bit(input logic b, input int gap);
    int g;
    repeat (gap) begin
      @(negedge clk);
      bit_valid_in = 1'b0;
      bit_in       = 1'($urandom);
    end
    @(negedge clk);
    bit_in       = b;
    bit_valid_in = 1'b1;
    g = 0;
    while (!bit_ready_out && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (g >= 40) chk("send_timeout", 32'(g), 32'd0);
    @(posedge clk);
  endtask

  task automatic send_field(input logic [4:0] code, input int n, input int x, input bit gaps);
    logic [31:0] xv;
    xv = 32'(x);
    for (int i = 4; i >= 0; i--) send_bit(code[i], gaps ? int'($urandom_range(0, 3)) : 0);
    for (int i = n - 1; i >= 0; i--) send_bit(xv[i], gaps ? int'($urandom_range(0, 3)) : 0);
  endtask

  // Full decode: field, one-cycle latency, value, handshake, return to accepting.
  task automatic run(input string tag, input logic [4:0] code, input int n, input int x,
                     input int exp_d, input logic exp_e, input bit gaps);
    send_field(code, n, x, gaps);
    @(negedge clk);
    bit_valid_in = 1'b0;
    chk({tag, "_vld"}, 32'(dist_valid_out), 32'd1);
    chk({tag, "_rdy_lo"}, 32'(bit_ready_out), 32'd0);
    chk({tag, "_dist"}, 32'(dist_out), 32'(exp_d));
    chk({tag, "_err"}, 32'(dist_err_out), 32'(exp_e));
    dist_ready_in = 1'b1;
    @(negedge clk);
    dist_ready_in = 1'b0;
    chk({tag, "_vld_drop"}, 32'(dist_valid_out), 32'd0);
    chk({tag, "_rdy_hi"}, 32'(bit_ready_out), 32'd1);
  endtask

  // Reference encoder: distance -> code, extra count, extra value.
  task automatic encode(input int d, output logic [4:0] c, output int n, output int x);
    logic [31:0] v;
    int p;
    v = 32'(d - 1);
    if (d <= 4) begin
      c = 5'(d - 1);
      n = 0;
      x = 0;
    end else begin
      p = 0;
      for (int i = 0; i < 16; i++) if (v[i]) p = i;
      c = 5'(2 * p + int'(v[p-1]));
      n = p - 1;
      x = int'(v & ((32'd1 << n) - 32'd1));
    end
  endtask

  initial begin
    logic [4:0] c;
    int n;
    int x;
    int d;
    int dlist[4];
    n_vec         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bit_in        = 1'b0;
    bit_valid_in  = 1'b0;
    dist_ready_in = 1'b0;
    #1;
    chk("rst_rdy", 32'(bit_ready_out), 32'd1);
    chk("rst_vld", 32'(dist_valid_out), 32'd0);
    chk("rst_dist", 32'(dist_out), 32'd0);
    chk("rst_err", 32'(dist_err_out), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run("c0", 5'd0, 0, 0, 1, 1'b0, 1'b0);
    run("c4", 5'd4, 1, 1, 6, 1'b0, 1'b0);
    run("c16", 5'd16, 7, 43, 300, 1'b0, 1'b0);
    run("c29", 5'd29, 13, 8191, 32768, 1'b0, 1'b0);
    run("c30", 5'd30, 0, 0, 0, 1'b1, 1'b0);
    run("c2", 5'd2, 0, 0, 3, 1'b0, 1'b0);
    run("c31", 5'd31, 0, 0, 0, 1'b1, 1'b0);

    // Backpressure: code 5 extra 0 -> 7, result held while downstream stalls.
    send_field(5'd5, 1, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bit_valid_in = 1'b1;
      bit_in       = 1'(i);
      chk("bp_rdy", 32'(bit_ready_out), 32'd0);
      chk("bp_vld", 32'(dist_valid_out), 32'd1);
      chk("bp_dist", 32'(dist_out), 32'd7);
    end
    @(negedge clk);
    bit_valid_in  = 1'b0;
    dist_ready_in = 1'b1;
    @(negedge clk);
    dist_ready_in = 1'b0;
    chk("bp_vld_drop", 32'(dist_valid_out), 32'd0);
    run("bp_next", 5'd1, 0, 0, 2, 1'b0, 1'b0);

    // Gaps: code 20 (base 1025) extra 300 -> 1325.
    run("gap20", 5'd20, 9, 300, 1325, 1'b0, 1'b1);

    // Reset after 8 bits of a code-29 field.
    send_field(5'd29, 3, 7, 1'b0);
    @(negedge clk);
    bit_valid_in = 1'b0;
    rst_n        = 1'b0;
    #1;
    chk("mrst_rdy", 32'(bit_ready_out), 32'd1);
    chk("mrst_vld", 32'(dist_valid_out), 32'd0);
    chk("mrst_dist", 32'(dist_out), 32'd0);
    chk("mrst_err", 32'(dist_err_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("mrst_next", 5'd29, 13, 0, 24577, 1'b0, 1'b0);

    // Round trip through the reference encoder.
    dlist = '{1, 4, 5, 32768};
    for (int i = 0; i < 28; i++) begin
      d = (i < 4) ? dlist[i] : int'($urandom_range(1, 32768));
      encode(d, c, n, x);
      run("rt", c, n, x, d, 1'b0, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
